// File: rtl/ins_enc_pkg.sv
// Shared definitions for the MIPS instruction encoder: symbolic ops, opcode and
// function-code constants, and small word-assembly helpers.
package ins_enc_pkg;

  typedef enum logic [5:0] {
    OP_SLL     = 6'd0,  OP_SRL   = 6'd1,  OP_SRA   = 6'd2,  OP_SLLV  = 6'd3,
    OP_SRLV    = 6'd4,  OP_SRAV  = 6'd5,  OP_JR    = 6'd6,  OP_JALR  = 6'd7,
    OP_SYSCALL = 6'd8,  OP_MFHI  = 6'd9,  OP_MTHI  = 6'd10, OP_MFLO  = 6'd11,
    OP_MTLO    = 6'd12, OP_MULT  = 6'd13, OP_MULTU = 6'd14, OP_DIV   = 6'd15,
    OP_DIVU    = 6'd16, OP_ADD   = 6'd17, OP_ADDU  = 6'd18, OP_SUB   = 6'd19,
    OP_SUBU    = 6'd20, OP_AND   = 6'd21, OP_OR    = 6'd22, OP_XOR   = 6'd23,
    OP_NOR     = 6'd24, OP_SLT   = 6'd25, OP_SLTU  = 6'd26, OP_BLTZ  = 6'd27,
    OP_BGEZ    = 6'd28, OP_J     = 6'd29, OP_JAL   = 6'd30, OP_BEQ   = 6'd31,
    OP_BNE     = 6'd32, OP_BLEZ  = 6'd33, OP_BGTZ  = 6'd34, OP_ADDI  = 6'd35,
    OP_ADDIU   = 6'd36, OP_SLTI  = 6'd37, OP_SLTIU = 6'd38, OP_ANDI  = 6'd39,
    OP_ORI     = 6'd40, OP_XORI  = 6'd41, OP_LUI   = 6'd42, OP_MFC0  = 6'd43,
    OP_MTC0    = 6'd44, OP_ERET  = 6'd45, OP_LB    = 6'd46, OP_LH    = 6'd47,
    OP_LW      = 6'd48, OP_LBU   = 6'd49, OP_LHU   = 6'd50, OP_SB    = 6'd51,
    OP_SH      = 6'd52, OP_SW    = 6'd53, OP_LI    = 6'd54, OP_MOVE  = 6'd55,
    OP_NOP     = 6'd56, OP_B     = 6'd57
  } enc_op_t;

  localparam logic [5:0] OPC_SPECIAL = 6'h00, OPC_REGIMM = 6'h01, OPC_J     = 6'h02,
                         OPC_JAL     = 6'h03, OPC_BEQ    = 6'h04, OPC_BNE   = 6'h05,
                         OPC_BLEZ    = 6'h06, OPC_BGTZ   = 6'h07, OPC_ADDI  = 6'h08,
                         OPC_ADDIU   = 6'h09, OPC_SLTI   = 6'h0A, OPC_SLTIU = 6'h0B,
                         OPC_ANDI    = 6'h0C, OPC_ORI    = 6'h0D, OPC_XORI  = 6'h0E,
                         OPC_LUI     = 6'h0F, OPC_COP0   = 6'h10, OPC_LB    = 6'h20,
                         OPC_LH      = 6'h21, OPC_LW     = 6'h23, OPC_LBU   = 6'h24,
                         OPC_LHU     = 6'h25, OPC_SB     = 6'h28, OPC_SH    = 6'h29,
                         OPC_SW      = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL   = 6'h02, FN_SRA  = 6'h03,
                         FN_SLLV = 6'h04, FN_SRLV  = 6'h06, FN_SRAV = 6'h07,
                         FN_JR   = 6'h08, FN_JALR  = 6'h09, FN_SYSCALL = 6'h0C,
                         FN_MFHI = 6'h10, FN_MTHI  = 6'h11, FN_MFLO = 6'h12,
                         FN_MTLO = 6'h13, FN_MULT  = 6'h18, FN_MULTU = 6'h19,
                         FN_DIV  = 6'h1A, FN_DIVU  = 6'h1B, FN_ADD  = 6'h20,
                         FN_ADDU = 6'h21, FN_SUB   = 6'h22, FN_SUBU = 6'h23,
                         FN_AND  = 6'h24, FN_OR    = 6'h25, FN_XOR  = 6'h26,
                         FN_NOR  = 6'h27, FN_SLT   = 6'h2A, FN_SLTU = 6'h2B,
                         FN_ERET = 6'h18;

  localparam logic [4:0] RT_BLTZ = 5'b00000, RT_BGEZ = 5'b00001;
  localparam logic [4:0] RS_MFC0 = 5'b00000, RS_MTC0 = 5'b00100, RS_ERET = 5'b10000;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {OPC_SPECIAL, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/ins_field_pack.sv
// Combinational field packer: turns one symbolic request into up to two
// native MIPS words and flags ops it does not recognise.
module ins_field_pack
  import ins_enc_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [31:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word0_o,
  output logic [31:0] word1_o,
  output logic        two_words_o,
  output logic        illegal_o
);

  logic [15:0] immHi;
  logic [15:0] immLo;
  logic [4:0]  jalrRd;

  assign immHi  = imm_i[31:16];
  assign immLo  = imm_i[15:0];
  assign jalrRd = (rd_i == 5'd0) ? 5'd31 : rd_i;

  always_comb begin
    word0_o     = '0;
    word1_o     = '0;
    two_words_o = 1'b0;
    illegal_o   = 1'b0;
    case (op_i)
      OP_SLL:     word0_o = rtype(5'd0, rt_i, rd_i, shamt_i, FN_SLL);
      OP_SRL:     word0_o = rtype(5'd0, rt_i, rd_i, shamt_i, FN_SRL);
      OP_SRA:     word0_o = rtype(5'd0, rt_i, rd_i, shamt_i, FN_SRA);
      OP_SLLV:    word0_o = rtype(rs_i, rt_i, rd_i, 5'd0, FN_SLLV);
      OP_SRLV:    word0_o = rtype(rs_i, rt_i, rd_i, 5'd0, FN_SRLV);
      OP_SRAV:    word0_o = rtype(rs_i, rt_i, rd_i, 5'd0, FN_SRAV);
      OP_JR:      word0_o = rtype(rs_i, 5'd0, 5'd0, 5'd0, FN_JR);
      OP_JALR:    word0_o = rtype(rs_i, 5'd0, jalrRd, 5'd0, FN_JALR);
      OP_SYSCALL: word0_o = 32'h0000_000C;
      OP_MFHI:    word0_o = rtype(5'd0, 5'd0, rd_i, 5'd0, FN_MFHI);
      OP_MFLO:    word0_o = rtype(5'd0, 5'd0, rd_i, 5'd0, FN_MFLO);
      OP_MTHI:    word0_o = rtype(rs_i, rt_i, 5'd0, 5'd0, FN_MTHI);
      OP_MTLO:    word0_o = rtype(rs_i, rt_i, 5'd0, 5'd0, FN_MTLO);
      OP_MULT:    word0_o = rtype(rs_i, rt_i, 5'd0, 5'd0, FN_MULT);
      OP_MULTU:   word0_o = rtype(rs_i, rt_i, 5'd0, 5'd0, FN_MULTU);
      OP_DIV:     word0_o = rtype(rs_i, rt_i, 5'd0, 5'd0, FN_DIV);
      OP_DIVU:    word0_o = rtype(rs_i, rt_i, 5'd0, 5'd0, FN_DIVU);
      OP_ADD:     word0_o = rtype(rs_i, rt_i, rd_i, shamt_i, FN_ADD);
      OP_ADDU:    word0_o = rtype(rs_i, rt_i, rd_i, shamt_i, FN_ADDU);
      OP_SUB:     word0_o = rtype(rs_i, rt_i, rd_i, shamt_i, FN_SUB);
      OP_SUBU:    word0_o = rtype(rs_i, rt_i, rd_i, shamt_i, FN_SUBU);
      OP_AND:     word0_o = rtype(rs_i, rt_i, rd_i, shamt_i, FN_AND);
      OP_OR:      word0_o = rtype(rs_i, rt_i, rd_i, shamt_i, FN_OR);
      OP_XOR:     word0_o = rtype(rs_i, rt_i, rd_i, shamt_i, FN_XOR);
      OP_NOR:     word0_o = rtype(rs_i, rt_i, rd_i, shamt_i, FN_NOR);
      OP_SLT:     word0_o = rtype(rs_i, rt_i, rd_i, shamt_i, FN_SLT);
      OP_SLTU:    word0_o = rtype(rs_i, rt_i, rd_i, shamt_i, FN_SLTU);
      OP_BLTZ:    word0_o = itype(OPC_REGIMM, rs_i, RT_BLTZ, immLo);
      OP_BGEZ:    word0_o = itype(OPC_REGIMM, rs_i, RT_BGEZ, immLo);
      OP_J:       word0_o = {OPC_J, target_i};
      OP_JAL:     word0_o = {OPC_JAL, target_i};
      OP_BEQ:     word0_o = itype(OPC_BEQ, rs_i, rt_i, immLo);
      OP_BNE:     word0_o = itype(OPC_BNE, rs_i, rt_i, immLo);
      OP_BLEZ:    word0_o = itype(OPC_BLEZ, rs_i, 5'd0, immLo);
      OP_BGTZ:    word0_o = itype(OPC_BGTZ, rs_i, 5'd0, immLo);
      OP_ADDI:    word0_o = itype(OPC_ADDI, rs_i, rt_i, immLo);
      OP_ADDIU:   word0_o = itype(OPC_ADDIU, rs_i, rt_i, immLo);
      OP_SLTI:    word0_o = itype(OPC_SLTI, rs_i, rt_i, immLo);
      OP_SLTIU:   word0_o = itype(OPC_SLTIU, rs_i, rt_i, immLo);
      OP_ANDI:    word0_o = itype(OPC_ANDI, rs_i, rt_i, immLo);
      OP_ORI:     word0_o = itype(OPC_ORI, rs_i, rt_i, immLo);
      OP_XORI:    word0_o = itype(OPC_XORI, rs_i, rt_i, immLo);
      OP_LUI:     word0_o = itype(OPC_LUI, 5'd0, rt_i, immLo);
      OP_MFC0:    word0_o = {OPC_COP0, RS_MFC0, rt_i, rd_i, 11'd0};
      OP_MTC0:    word0_o = {OPC_COP0, RS_MTC0, rt_i, rd_i, 11'd0};
      OP_ERET:    word0_o = {OPC_COP0, RS_ERET, 15'd0, FN_ERET};
      OP_LB:      word0_o = itype(OPC_LB, rs_i, rt_i, immLo);
      OP_LH:      word0_o = itype(OPC_LH, rs_i, rt_i, immLo);
      OP_LW:      word0_o = itype(OPC_LW, rs_i, rt_i, immLo);
      OP_LBU:     word0_o = itype(OPC_LBU, rs_i, rt_i, immLo);
      OP_LHU:     word0_o = itype(OPC_LHU, rs_i, rt_i, immLo);
      OP_SB:      word0_o = itype(OPC_SB, rs_i, rt_i, immLo);
      OP_SH:      word0_o = itype(OPC_SH, rs_i, rt_i, immLo);
      OP_SW:      word0_o = itype(OPC_SW, rs_i, rt_i, immLo);
      OP_NOP:     word0_o = 32'h0000_0000;
      OP_MOVE:    word0_o = rtype(rs_i, 5'd0, rd_i, 5'd0, FN_ADDU);
      OP_B:       word0_o = itype(OPC_BEQ, 5'd0, 5'd0, immLo);
      // LI picks the shortest legal sequence for the constant
      OP_LI: begin
        if (immHi == 16'd0) begin
          word0_o = itype(OPC_ORI, 5'd0, rt_i, immLo);
        end else if (immLo == 16'd0) begin
          word0_o = itype(OPC_LUI, 5'd0, rt_i, immHi);
        end else begin
          word0_o     = itype(OPC_LUI, 5'd0, rt_i, immHi);
          word1_o     = itype(OPC_ORI, rt_i, rt_i, immLo);
          two_words_o = 1'b1;
        end
      end
      default:    illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ins_encoder.sv
// Streaming MIPS instruction encoder: accepts symbolic requests, emits native
// words with a one-deep pending register for two-word pseudo-op expansions.
module ins_encoder
  import ins_enc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_op,
  input  logic [4:0]       req_rs,
  input  logic [4:0]       req_rt,
  input  logic [4:0]       req_rd,
  input  logic [4:0]       req_shamt,
  input  logic [31:0]      req_imm,
  input  logic [25:0]      req_target,
  output logic             ins_valid,
  input  logic             ins_ready,
  output logic [31:0]      ins,
  output logic             ins_last,
  output logic             err,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt
);

  typedef enum logic {IDLE, PEND} state_t;

  state_t            state_q;
  logic [31:0]       insWord_q;
  logic [31:0]       pendWord_q;
  logic              insLast_q;
  logic              insValid_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [31:0] word0;
  logic [31:0] word1;
  logic        twoWords;
  logic        illegal;
  logic        accept;
  logic        xfer;

  ins_field_pack u_pack (
    .op_i        (req_op),
    .rs_i        (req_rs),
    .rt_i        (req_rt),
    .rd_i        (req_rd),
    .shamt_i     (req_shamt),
    .imm_i       (req_imm),
    .target_i    (req_target),
    .word0_o     (word0),
    .word1_o     (word1),
    .two_words_o (twoWords),
    .illegal_o   (illegal)
  );

  // Accepting while the held word leaves avoids a bubble between requests
  assign req_ready = (state_q == IDLE) && (!insValid_q || ins_ready);
  assign accept    = req_valid && req_ready;
  assign xfer      = insValid_q && ins_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      insWord_q  <= '0;
      pendWord_q <= '0;
      insLast_q  <= 1'b0;
      insValid_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      err_q <= accept && illegal;
      if (xfer) begin
        cnt_q <= cnt_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (accept && !illegal) begin
            insWord_q  <= word0;
            insLast_q  <= !twoWords;
            insValid_q <= 1'b1;
            if (twoWords) begin
              pendWord_q <= word1;
              state_q    <= PEND;
            end
          end else if (xfer) begin
            insValid_q <= 1'b0;
          end
        end
        PEND: begin
          if (xfer) begin
            insWord_q <= pendWord_q;
            insLast_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ins_valid = insValid_q;
  assign ins       = insWord_q;
  assign ins_last  = insLast_q;
  assign err       = err_q;
  assign busy      = insValid_q || (state_q == PEND);
  assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_ins_encoder.sv
// Directed bench for ins_encoder: a table of single requests with hand-computed
// words, plus backpressure, illegal-op and mid-expansion reset sequences.
module tb_ins_encoder;
  import ins_enc_pkg::*;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [31:0] imm;
    logic [25:0] target;
    logic [31:0] exp0;
    logic [31:0] exp1;
    logic        two;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_op;
  logic [4:0]  req_rs;
  logic [4:0]  req_rt;
  logic [4:0]  req_rd;
  logic [4:0]  req_shamt;
  logic [31:0] req_imm;
  logic [25:0] req_target;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins;
  logic        ins_last;
  logic        err;
  logic        busy;
  logic [15:0] word_cnt;

  int total;
  int bad;
  int expCnt;
  vec_t vecs[$];

  ins_encoder #(.CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_rs     (req_rs),
    .req_rt     (req_rt),
    .req_rd     (req_rd),
    .req_shamt  (req_shamt),
    .req_imm    (req_imm),
    .req_target (req_target),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .ins        (ins),
    .ins_last   (ins_last),
    .err        (err),
    .busy       (busy),
    .word_cnt   (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One compare: bumps total, and bad plus a FAIL line on disagreement
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic driveFields(input vec_t v);
    req_op     = v.op;
    req_rs     = v.rs;
    req_rt     = v.rt;
    req_rd     = v.rd;
    req_shamt  = v.shamt;
    req_imm    = v.imm;
    req_target = v.target;
  endtask

  // Presents a request at a falling edge, waits (bounded) for acceptance and
  // returns at the falling edge after the accepting rising edge.
  task automatic applyStimulus(input vec_t v);
    int n;
    driveFields(v);
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL %s accept-timeout: got req_ready=0 want 1", v.name);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic runVector(input vec_t v);
    ins_ready = 1'b1;
    applyStimulus(v);
    checkOutput({v.name, " valid0"}, {31'd0, ins_valid}, 32'd1);
    checkOutput({v.name, " word0"}, ins, v.exp0);
    checkOutput({v.name, " last0"}, {31'd0, ins_last}, {31'd0, !v.two});
    expCnt++;
    if (v.two) begin
      checkOutput({v.name, " ready-in-pend"}, {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      checkOutput({v.name, " word1"}, ins, v.exp1);
      checkOutput({v.name, " last1"}, {31'd0, ins_last}, 32'd1);
      expCnt++;
    end
    @(negedge clk);
    checkOutput({v.name, " drained"}, {31'd0, ins_valid}, 32'd0);
    checkOutput({v.name, " cnt"}, {16'd0, word_cnt}, expCnt);
  endtask

  function automatic vec_t mk(input string name, input enc_op_t op, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                              input logic [31:0] imm, input logic [25:0] tgt,
                              input logic [31:0] e0, input logic [31:0] e1, input logic two);
    vec_t v;
    v.name = name; v.op = op; v.rs = rs; v.rt = rt; v.rd = rd; v.shamt = sh;
    v.imm = imm; v.target = tgt; v.exp0 = e0; v.exp1 = e1; v.two = two;
    return v;
  endfunction

  initial begin
    vec_t liV;
    vec_t adduV;
    vec_t badV;
    total = 0;
    bad = 0;
    expCnt = 0;

    vecs.push_back(mk("addu",    OP_ADDU,    1, 2, 3, 0, 32'h0, 26'h0, 32'h0022_1821, 32'h0, 0));
    vecs.push_back(mk("li2",     OP_LI,      0, 8, 0, 0, 32'h1234_5678, 26'h0, 32'h3C08_1234, 32'h3508_5678, 1));
    vecs.push_back(mk("li-lo",   OP_LI,      0, 8, 0, 0, 32'h0000_00FF, 26'h0, 32'h3408_00FF, 32'h0, 0));
    vecs.push_back(mk("li-hi",   OP_LI,      0, 8, 0, 0, 32'h0001_0000, 26'h0, 32'h3C08_0001, 32'h0, 0));
    vecs.push_back(mk("li-zero", OP_LI,      0, 3, 0, 0, 32'h0000_0000, 26'h0, 32'h3403_0000, 32'h0, 0));
    vecs.push_back(mk("jal",     OP_JAL,     0, 0, 0, 0, 32'h0, 26'h010_0000, 32'h0C10_0000, 32'h0, 0));
    vecs.push_back(mk("mtc0",    OP_MTC0,    0, 4, 12, 0, 32'h0, 26'h0, 32'h4084_6000, 32'h0, 0));
    vecs.push_back(mk("bgez",    OP_BGEZ,    5, 0, 0, 0, 32'h0000_FFFF, 26'h0, 32'h04A1_FFFF, 32'h0, 0));
    vecs.push_back(mk("eret",    OP_ERET,    0, 0, 0, 0, 32'h0, 26'h0, 32'h4200_0018, 32'h0, 0));
    vecs.push_back(mk("nop",     OP_NOP,     3, 4, 5, 6, 32'h0, 26'h0, 32'h0000_0000, 32'h0, 0));
    vecs.push_back(mk("move",    OP_MOVE,    7, 9, 5, 0, 32'h0, 26'h0, 32'h00E0_2821, 32'h0, 0));
    vecs.push_back(mk("b",       OP_B,       2, 3, 0, 0, 32'h0000_0010, 26'h0, 32'h1000_0010, 32'h0, 0));
    vecs.push_back(mk("sll",     OP_SLL,     9, 2, 4, 3, 32'h0, 26'h0, 32'h0002_20C0, 32'h0, 0));
    vecs.push_back(mk("jalr",    OP_JALR,    6, 0, 0, 0, 32'h0, 26'h0, 32'h00C0_F809, 32'h0, 0));
    vecs.push_back(mk("syscall", OP_SYSCALL, 3, 3, 3, 3, 32'h0, 26'h0, 32'h0000_000C, 32'h0, 0));
    vecs.push_back(mk("mfhi",    OP_MFHI,    1, 1, 2, 0, 32'h0, 26'h0, 32'h0000_1010, 32'h0, 0));
    vecs.push_back(mk("addiu",   OP_ADDIU,  29, 29, 0, 0, 32'h0000_FFF8, 26'h0, 32'h27BD_FFF8, 32'h0, 0));
    vecs.push_back(mk("sw",      OP_SW,     29, 31, 0, 0, 32'h0000_0004, 26'h0, 32'hAFBF_0004, 32'h0, 0));

    rst = 1'b1;
    req_valid = 1'b0;
    ins_ready = 1'b0;
    driveFields(vecs[0]);
    repeat (2) @(negedge clk);
    checkOutput("rst req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rst ins_valid", {31'd0, ins_valid}, 32'd0);
    checkOutput("rst ins", ins, 32'd0);
    checkOutput("rst ins_last", {31'd0, ins_last}, 32'd0);
    checkOutput("rst err", {31'd0, err}, 32'd0);
    checkOutput("rst busy", {31'd0, busy}, 32'd0);
    checkOutput("rst word_cnt", {16'd0, word_cnt}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) runVector(vecs[i]);

    // Backpressure mid-LI with a second request waiting behind it
    liV   = vecs[1];
    adduV = vecs[0];
    ins_ready = 1'b0;
    applyStimulus(liV);
    req_valid = 1'b1;
    driveFields(adduV);
    for (int c = 0; c < 5; c++) begin
      checkOutput("bp word0 held", ins, 32'h3C08_1234);
      checkOutput("bp last0 held", {31'd0, ins_last}, 32'd0);
      checkOutput("bp ready low", {31'd0, req_ready}, 32'd0);
      checkOutput("bp busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    checkOutput("bp cnt frozen", {16'd0, word_cnt}, expCnt);
    ins_ready = 1'b1;
    @(negedge clk);
    expCnt++;
    checkOutput("bp word1", ins, 32'h3508_5678);
    checkOutput("bp last1", {31'd0, ins_last}, 32'd1);
    checkOutput("bp ready back", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    expCnt++;
    req_valid = 1'b0;
    checkOutput("bp addu follows", ins, 32'h0022_1821);
    checkOutput("bp addu last", {31'd0, ins_last}, 32'd1);
    @(negedge clk);
    expCnt++;
    checkOutput("bp drained", {31'd0, ins_valid}, 32'd0);
    checkOutput("bp cnt", {16'd0, word_cnt}, expCnt);

    // Illegal op: consumed, one-cycle err, nothing emitted
    badV = adduV;
    badV.name = "illegal";
    badV.op = 6'h3F;
    applyStimulus(badV);
    checkOutput("illegal err", {31'd0, err}, 32'd1);
    checkOutput("illegal no word", {31'd0, ins_valid}, 32'd0);
    checkOutput("illegal ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    checkOutput("illegal err clears", {31'd0, err}, 32'd0);
    checkOutput("illegal cnt", {16'd0, word_cnt}, expCnt);

    // Asynchronous reset while an expansion is pending
    ins_ready = 1'b0;
    applyStimulus(liV);
    checkOutput("pre-rst busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid-rst ins_valid", {31'd0, ins_valid}, 32'd0);
    checkOutput("mid-rst busy", {31'd0, busy}, 32'd0);
    checkOutput("mid-rst word_cnt", {16'd0, word_cnt}, 32'd0);
    checkOutput("mid-rst req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    expCnt = 0;
    @(negedge clk);
    runVector(liV);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
